// File: rtl/s_sub_serial_if.sv
// Start/done handshake and operand/result bus for the bit-serial subtractor.
// The sequencing FSM side is the master; the subtractor is the slave.
interface s_sub_serial_if #(
  parameter int W = 9
);
  logic                start;
  logic        [W-1:0] A;
  logic        [W-1:0] B;
  logic                busy;
  logic                done;
  logic signed [W:0]   Y;
  logic                neg;
  logic                zero;

  modport master (
    output start, A, B,
    input  busy, done, Y, neg, zero
  );

  modport slave (
    input  start, A, B,
    output busy, done, Y, neg, zero
  );
endinterface

// File: rtl/s_sub_serial.sv
// Bit-serial subtractor Y = A - B, one bit per clock LSB first, with the final
// borrow becoming the sign bit of the (W+1)-bit two's-complement result.
module s_sub_serial #(
  parameter int W = 9
) (
  input logic            clk,
  input logic            rst_n,
  s_sub_serial_if.slave  bus
);
  localparam int CW = (W > 2) ? $clog2(W) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [W-1:0]      a_sh;
  logic [W-1:0]      b_sh;
  logic [W-1:0]      res;
  logic              br;
  logic [CW-1:0]     cnt;

  logic              a0;
  logic              b0;
  logic              d;
  logic              br_nx;
  logic [W-1:0]      res_nx;

  always_comb begin
    a0     = a_sh[0];
    b0     = b_sh[0];
    d      = a0 ^ b0 ^ br;
    br_nx  = (~a0 & b0) | (~(a0 ^ b0) & br);
    res_nx = {d, res[W-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      bus.Y    <= '0;
      bus.neg  <= 1'b0;
      bus.zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.A;
            b_sh  <= bus.B;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_nx;
          res  <= res_nx;
          cnt  <= cnt + 1'b1;
          // Results are registered on the edge that enters DONE so they are
          // already valid while done is high.
          if (cnt == CW'(W - 1)) begin
            state    <= DONE;
            bus.Y    <= $signed({br_nx, res_nx});
            bus.neg  <= br_nx;
            bus.zero <= (res_nx == '0) && !br_nx;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
endmodule

// File: tb/tb_s_sub_serial.sv
// Randomized self-checking bench for s_sub_serial against an integer-arithmetic
// reference of A - B.
module tb_s_sub_serial;
  localparam int W = 9;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  s_sub_serial_if #(.W(W)) bus ();

  s_sub_serial #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  function automatic logic signed [W:0] ref_y(input int a, input int b);
    int diff;
    diff = a - b;
    return (W+1)'(diff);
  endfunction

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy === 1'b1 && k < 4 * W) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  // cyc counts clock edges after the accepting edge until done is seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int cyc, output bit held);
    logic signed [W:0] y0;
    wait_idle();
    y0 = bus.Y;
    held = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A = W'($urandom);
    bus.B = W'($urandom);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 4 * W) begin
      if (bus.Y !== y0) held = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc;
    bit held;
    logic signed [W:0] ey;
    run_op(a, b, cyc, held);
    ey = ref_y(int'(a), int'(b));
    n_chk++;
    if (bus.done !== 1'b1) $display("FAIL %s done: got %b, required 1", name, bus.done);
    else n_pass++;
    // Done cycle number with the accepting cycle counted as cycle 1: W+1.
    n_chk++;
    if (cyc + 1 != W + 1) $display("FAIL %s latency: got %0d, required %0d", name, cyc + 1, W + 1);
    else n_pass++;
    n_chk++;
    if (bus.Y !== ey) $display("FAIL %s Y (A=%0d B=%0d): got %h, required %h", name, a, b, bus.Y, ey);
    else n_pass++;
    n_chk++;
    if (bus.neg !== (a < b)) $display("FAIL %s neg: got %b, required %b", name, bus.neg, (a < b));
    else n_pass++;
    n_chk++;
    if (bus.zero !== (a == b)) $display("FAIL %s zero: got %b, required %b", name, bus.zero, (a == b));
    else n_pass++;
    n_chk++;
    if (!held) $display("FAIL %s hold: Y changed before done, got 0, required 1", name);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    #13;
    n_chk++;
    if ({bus.busy, bus.done, bus.neg, bus.zero} !== 4'b0000)
      $display("FAIL reset flags: got %b, required 0000", {bus.busy, bus.done, bus.neg, bus.zero});
    else n_pass++;
    n_chk++;
    if (bus.Y !== '0) $display("FAIL reset Y: got %h, required 0", bus.Y);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (bus.busy !== 1'b0) $display("FAIL idle busy: got %b, required 0", bus.busy);
    else n_pass++;
  endtask

  task automatic test_directed();
    check_op("a200_b55", 9'd200, 9'd55);
    check_op("a5_b7", 9'd5, 9'd7);
    check_op("a511_b0", 9'd511, 9'd0);
    check_op("a0_b511", 9'd0, 9'd511);
    check_op("a300_b300", 9'd300, 9'd300);
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom);
      b = (i % 6 == 0) ? a : W'($urandom);
      check_op("random", a, b);
    end
  endtask

  task automatic test_start_held();
    logic [W-1:0] a1, b1, a2, b2;
    int cyc;
    a1 = W'($urandom);
    b1 = W'($urandom);
    a2 = W'($urandom);
    b2 = W'($urandom);
    wait_idle();
    bus.A = a1;
    bus.B = b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 4 * W) begin
      bus.A = W'($urandom);
      bus.B = W'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    n_chk++;
    if (cyc != W) $display("FAIL held_start first latency: got %0d, required %0d", cyc, W);
    else n_pass++;
    n_chk++;
    if (bus.Y !== ref_y(int'(a1), int'(b1)))
      $display("FAIL held_start first Y: got %h, required %h", bus.Y, ref_y(int'(a1), int'(b1)));
    else n_pass++;
    bus.A = a2;
    bus.B = b2;
    @(posedge clk); #1;
    n_chk++;
    if ({bus.busy, bus.done} !== 2'b00)
      $display("FAIL held_start after done busy/done: got %b, required 00", {bus.busy, bus.done});
    else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if (bus.busy !== 1'b1) $display("FAIL held_start reaccept busy: got %b, required 1", bus.busy);
    else n_pass++;
    bus.start = 1'b0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 4 * W) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_chk++;
    if (cyc != W) $display("FAIL held_start second latency: got %0d, required %0d", cyc, W);
    else n_pass++;
    n_chk++;
    if (bus.Y !== ref_y(int'(a2), int'(b2)))
      $display("FAIL held_start second Y: got %h, required %h", bus.Y, ref_y(int'(a2), int'(b2)));
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    bit saw_done;
    bit saw_busy;
    check_op("pre_reset", 9'd400, 9'd17);
    wait_idle();
    bus.A = 9'd123;
    bus.B = 9'd45;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.busy, bus.done, bus.neg, bus.zero} !== 4'b0000)
      $display("FAIL midreset flags: got %b, required 0000", {bus.busy, bus.done, bus.neg, bus.zero});
    else n_pass++;
    n_chk++;
    if (bus.Y !== '0) $display("FAIL midreset Y: got %h, required 0", bus.Y);
    else n_pass++;
    saw_done = 1'b0;
    saw_busy = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) saw_done = 1'b1;
      if (bus.busy === 1'b1) saw_busy = 1'b1;
    end
    rst_n = 1'b1;
    repeat (W + 3) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) saw_done = 1'b1;
      if (bus.busy === 1'b1) saw_busy = 1'b1;
    end
    n_chk++;
    if (saw_done) $display("FAIL midreset done pulse: got 1, required 0");
    else n_pass++;
    n_chk++;
    if (saw_busy) $display("FAIL midreset busy after reset: got 1, required 0");
    else n_pass++;
    check_op("post_reset", 9'd88, 9'd301);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    test_reset();
    test_directed();
    test_random();
    test_start_held();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
